toggle_pulse_tx: RTL and testbench



---
 rtl/toggle_pulse_pkg.sv | 21 ++
 rtl/bit_sync_chain.sv | 20 ++
 rtl/toggle_pulse_tx.sv | 126 ++++++++++++
 tb/tb_toggle_pulse_tx.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_pulse_pkg.sv
// Shared types and defaults for the toggle pulse-transfer source end.
package toggle_pulse_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } tp_tx_state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int TIMEOUT_CYC_DEF = 1024;

  // Out-of-range depths are pulled to the nearest legal value.
  function automatic int sync_stages_clamp(input int n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/bit_sync_chain.sv
// Multi-flop single-bit resynchronizer, reset to 0; used on both ends of the toggle link.
module bit_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], din};
  end

  assign dout = sr[STAGES-1];

endmodule

// File: rtl/toggle_pulse_tx.sv
// Source end of the toggle pulse handshake: flips req per event, waits for the resynced ack, queues pulses that arrive meanwhile.
// Optional acknowledge-timeout flag built when TOGGLE_PULSE_TX_TIMEOUT_EN is defined.
module toggle_pulse_tx
  import toggle_pulse_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             data_i,
  input  logic             ack_tgl_i,
  input  logic             clr_err_i,
  output logic             req_tgl_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] pend_o,
  output logic             ovf_o,
  output logic             tmo_o
);

  localparam int SYNC_N = sync_stages_clamp(SYNC_STAGES);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  tp_tx_state_t state;
  logic ack_s;
  logic launch;
  logic inc;
  logic dec;
  logic drop;
  logic ack_match;

  bit_sync_chain #(.STAGES(SYNC_N)) u_ack_sync (
    .clk  (clk_i),
    .rst  (arst_i),
    .din  (ack_tgl_i),
    .dout (ack_s)
  );

  // A launch drains the counter first; a pulse only bypasses it when nothing is queued.
  always_comb begin
    launch    = 1'b0;
    dec       = 1'b0;
    inc       = 1'b0;
    drop      = 1'b0;
    ack_match = (ack_s == req_tgl_o);
    if (state == IDLE) begin
      launch = (pend_o != '0) || data_i;
      dec    = (pend_o != '0);
    end
    inc  = data_i && !(launch && !dec);
    drop = inc && !dec && (pend_o == PEND_MAX);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state     <= IDLE;
      req_tgl_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            req_tgl_o <= ~req_tgl_o;
            busy_o    <= 1'b1;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_match) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pend_o <= '0;
    end else if (inc && !dec && !drop) begin
      pend_o <= pend_o + 1'b1;
    end else if (dec && !inc) begin
      pend_o <= pend_o - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)         ovf_o <= 1'b0;
    else if (drop)      ovf_o <= 1'b1;
    else if (clr_err_i) ovf_o <= 1'b0;
  end

`ifdef TOGGLE_PULSE_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYC);

  logic [TW-1:0] tmo_cnt;

  // Counter sits at 0 in IDLE so every WAIT_ACK entry starts fresh; it saturates at the limit.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tmo_cnt <= '0;
      tmo_o   <= 1'b0;
    end else begin
      if (state == IDLE)          tmo_cnt <= '0;
      else if (tmo_cnt != TMO_LIM) tmo_cnt <= tmo_cnt + 1'b1;

      if (state == WAIT_ACK && tmo_cnt == TMO_LIM - 1'b1) tmo_o <= 1'b1;
      else if (clr_err_i)                                 tmo_o <= 1'b0;
    end
  end
`else
  assign tmo_o = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_pulse_tx.sv
// Scoreboarded bench for toggle_pulse_tx: expected req toggle levels queued per accepted event, checked by a monitor.
module tb_toggle_pulse_tx;

  localparam int CW = 2;
  localparam int SS = 2;
  localparam int TC = 16;
`ifdef TOGGLE_PULSE_TX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic          data_i;
  logic          ack_tgl_i;
  logic          clr_err_i;
  logic          req_tgl_o;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] pend_o;
  logic          ovf_o;
  logic          tmo_o;

  toggle_pulse_tx #(.CNT_W(CW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TC)) dut (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .data_i    (data_i),
    .ack_tgl_i (ack_tgl_i),
    .clr_err_i (clr_err_i),
    .req_tgl_o (req_tgl_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .pend_o    (pend_o),
    .ovf_o     (ovf_o),
    .tmo_o     (tmo_o)
  );

  always #5 clk_i = ~clk_i;

  int   vectors     = 0;
  int   miscompares = 0;
  int   done_cnt    = 0;
  logic exp_q[$];
  logic exp_lvl     = 1'b0;
  logic prev_req    = 1'b0;
  logic mon_exp;
  bit   mon_en      = 1'b0;
  bit   echo_en     = 1'b0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_launch();
    exp_lvl = ~exp_lvl;
    exp_q.push_back(exp_lvl);
  endtask

  // Monitor: every req level change must match the next queued launch.
  initial begin
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        if (done_o) done_cnt++;
        if (req_tgl_o !== prev_req) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL req_toggle: unexpected toggle to %b with nothing queued", req_tgl_o);
          end else begin
            mon_exp = exp_q.pop_front();
            if (req_tgl_o !== mon_exp) begin
              miscompares++;
              $display("FAIL req_toggle: got %b expected %b", req_tgl_o, mon_exp);
            end
          end
          prev_req = req_tgl_o;
        end
      end
    end
  end

  // Far side: echoes the request 3 clocks after it sees a mismatch.
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      if (echo_en && ack_tgl_i !== req_tgl_o) begin
        repeat (3) @(posedge clk_i);
        #2;
        if (echo_en) ack_tgl_i = req_tgl_o;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(pend_o == 0 && !busy_o && exp_q.size() == 0) && n < 300) begin
      tick();
      n++;
    end
    repeat (2) tick();
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $display("FAIL %s_drain: timeout pend_o=%0d busy_o=%b queued=%0d", name, pend_o, busy_o, exp_q.size());
    end
  endtask

  task automatic test_reset();
    arst_i = 1'b1; data_i = 1'b0; ack_tgl_i = 1'b0; clr_err_i = 1'b0;
    #12;
    vectors++;
    if ({req_tgl_o, busy_o, done_o, pend_o, ovf_o, tmo_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b busy=%b done=%b pend=%0d ovf=%b tmo=%b expected all 0",
               req_tgl_o, busy_o, done_o, pend_o, ovf_o, tmo_o);
    end
    @(negedge clk_i);
    arst_i   = 1'b0;
    prev_req = 1'b0;
    mon_en   = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit pend_seen;
    int d0;
    echo_en = 1'b0;
    d0 = done_cnt;
    pend_seen = 1'b0;
    data_i = 1'b1;
    push_launch();
    tick();
    data_i = 1'b0;
    vectors++;
    if (req_tgl_o !== 1'b1 || busy_o !== 1'b1 || pend_o !== 0) begin
      miscompares++;
      $display("FAIL single_launch: req=%b busy=%b pend=%0d expected 1 1 0", req_tgl_o, busy_o, pend_o);
    end
    repeat (5) begin
      tick();
      if (pend_o != 0) pend_seen = 1'b1;
    end
    ack_tgl_i = 1'b1;
    for (int i = 1; i <= SS + 1; i++) begin
      tick();
      if (pend_o != 0) pend_seen = 1'b1;
      vectors++;
      if (done_o !== (i == SS + 1)) begin
        miscompares++;
        $display("FAIL single_done_lat: edge %0d after echo done=%b expected %b", i, done_o, (i == SS + 1));
      end
    end
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_busy_clear: busy=%b expected 0", busy_o);
    end
    tick();
    vectors++;
    if (done_o !== 1'b0 || pend_seen) begin
      miscompares++;
      $display("FAIL single_tail: done=%b pend_nonzero=%b expected 0 0", done_o, pend_seen);
    end
    tick();
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_burst();
    int d0;
    int pmax;
    echo_en = 1'b1;
    d0 = done_cnt;
    pmax = 0;
    for (int i = 0; i < 3; i++) begin
      data_i = 1'b1;
      push_launch();
      tick();
      if (int'(pend_o) > pmax) pmax = int'(pend_o);
    end
    data_i = 1'b0;
    for (int n = 0; n < 100 && (pend_o != 0 || busy_o); n++) begin
      tick();
      if (int'(pend_o) > pmax) pmax = int'(pend_o);
    end
    wait_idle("burst");
    vectors++;
    if (pmax !== 2) begin
      miscompares++;
      $display("FAIL burst_pend_peak: got %0d expected 2", pmax);
    end
    vectors++;
    if (done_cnt - d0 !== 3) begin
      miscompares++;
      $display("FAIL burst_done_count: got %0d expected 3", done_cnt - d0);
    end
  endtask

  task automatic test_overflow();
    int d0;
    echo_en = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      data_i = 1'b1;
      if (i < 4) push_launch();
      tick();
    end
    data_i = 1'b0;
    vectors++;
    if (pend_o !== 2'd3 || ovf_o !== 1'b1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: pend=%0d ovf=%b busy=%b expected 3 1 1", pend_o, ovf_o, busy_o);
    end
    data_i = 1'b1;
    clr_err_i = 1'b1;
    tick();
    data_i = 1'b0;
    clr_err_i = 1'b0;
    vectors++;
    if (ovf_o !== 1'b1 || pend_o !== 2'd3) begin
      miscompares++;
      $display("FAIL ovf_set_wins: ovf=%b pend=%0d expected 1 3", ovf_o, pend_o);
    end
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    vectors++;
    if (ovf_o !== 1'b0 || pend_o !== 2'd3) begin
      miscompares++;
      $display("FAIL ovf_clear: ovf=%b pend=%0d expected 0 3", ovf_o, pend_o);
    end
    echo_en = 1'b1;
    wait_idle("ovf");
    vectors++;
    if (done_cnt - d0 !== 4) begin
      miscompares++;
      $display("FAIL ovf_done_count: got %0d expected 4", done_cnt - d0);
    end
  endtask

  task automatic test_coincide();
    int d0;
    int n;
    echo_en = 1'b0;
    d0 = done_cnt;
    data_i = 1'b1; push_launch(); tick();
    data_i = 1'b1; push_launch(); tick();
    data_i = 1'b0;
    ack_tgl_i = req_tgl_o;
    n = 0;
    while (done_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 20 || pend_o !== 2'd1) begin
      miscompares++;
      $display("FAIL coincide_setup: waited=%0d pend=%0d expected done and pend 1", n, pend_o);
    end
    data_i = 1'b1;
    push_launch();
    tick();
    data_i = 1'b0;
    vectors++;
    if (pend_o !== 2'd1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL coincide_pend: pend=%0d busy=%b expected 1 1", pend_o, busy_o);
    end
    echo_en = 1'b1;
    wait_idle("coincide");
    vectors++;
    if (done_cnt - d0 !== 3) begin
      miscompares++;
      $display("FAIL coincide_done_count: got %0d expected 3", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    echo_en = 1'b0;
    data_i = 1'b1; push_launch(); tick();
    data_i = 1'b0;
    tick();
    #2;
    mon_en = 1'b0;
    arst_i = 1'b1;
    #1;
    vectors++;
    if ({req_tgl_o, busy_o, done_o, pend_o, ovf_o, tmo_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: req=%b busy=%b done=%b pend=%0d ovf=%b tmo=%b expected all 0",
               req_tgl_o, busy_o, done_o, pend_o, ovf_o, tmo_o);
    end
    ack_tgl_i = 1'b0;
    exp_q.delete();
    exp_lvl = 1'b0;
    tick();
    @(negedge clk_i);
    arst_i = 1'b0;
    prev_req = 1'b0;
    mon_en = 1'b1;
    tick();
    data_i = 1'b1; push_launch(); tick();
    data_i = 1'b0;
    vectors++;
    if (req_tgl_o !== 1'b1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_relaunch: req=%b busy=%b expected 1 1", req_tgl_o, busy_o);
    end
    echo_en = 1'b1;
    wait_idle("reset_mid");
  endtask

  task automatic test_timeout();
    int d0;
    echo_en = 1'b0;
    d0 = done_cnt;
    data_i = 1'b1; push_launch(); tick();
    data_i = 1'b0;
    for (int i = 2; i <= TC + 1; i++) begin
      tick();
      if (i == TC || i == TC + 1) begin
        vectors++;
        if (tmo_o !== (TMO_EN && i == TC + 1) || busy_o !== 1'b1) begin
          miscompares++;
          $display("FAIL timeout_flag: cycle %0d tmo=%b busy=%b expected %b 1", i, tmo_o, busy_o, (TMO_EN && i == TC + 1));
        end
      end
    end
    ack_tgl_i = req_tgl_o;
    wait_idle("timeout");
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL timeout_late_ack: done count %0d expected 1", done_cnt - d0);
    end
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    vectors++;
    if (tmo_o !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: tmo=%b expected 0", tmo_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_coincide();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
